// File: rtl/rc4_pkg.sv
// Shared types for the RC4 S-box sequencer: FSM state encoding, byte type and S-box depth.
package rc4_pkg;

  localparam int SBOX_DEPTH = 256;

  typedef logic [7:0] byte_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_INIT,
    ST_K_RDI,
    ST_K_RDJ,
    ST_K_WR1,
    ST_K_WR2,
    ST_READY,
    ST_P_RDI,
    ST_P_RDJ,
    ST_P_WR1,
    ST_P_WR2,
    ST_P_RDK,
    ST_P_OUT
  } rc4_state_e;

endpackage

// File: rtl/rc4_sched.sv
// RC4 sequencer: S-box init, key scheduling and keystream generation driven
// through one read port and one write port of an external 256x8 S-box RAM.
module rc4_sched
  import rc4_pkg::*;
#(
  parameter int SBOX_AW = 8,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               key_setup_en,
  input  logic [7:0]         key_len,
  output logic [7:0]         key_addr,
  input  logic [7:0]         key_data,
  input  logic               cipher_req,
  input  logic [CNT_W-1:0]   ks_count,
  output logic               ks_valid,
  input  logic               ks_ready,
  output logic [7:0]         ks_byte,
  output logic               key_ready,
  output logic               busy,
  output logic               done,
  output logic [SBOX_AW-1:0] sbox_raddr,
  input  logic [7:0]         sbox_rdata,
  output logic               sbox_wen,
  output logic [SBOX_AW-1:0] sbox_waddr,
  output logic [7:0]         sbox_wdata,
  output rc4_state_e         dbg_state_o
);

  rc4_state_e       state_q;
  byte_t            i_q, j_q, kidx_q, si_q, sj_q, key_len_q;
  logic [CNT_W-1:0] rem_q;
  logic             ks_valid_q, key_ready_q, busy_q, done_q;

  byte_t i_inc, j_ksa, j_prga, kidx_last, out_addr;
  byte_t raddr_c, waddr_c, wdata_c;
  logic  wen_c, start_setup;

  assign i_inc     = i_q + 8'd1;
  assign j_ksa     = j_q + sbox_rdata + key_data;
  assign j_prga    = j_q + sbox_rdata;
  assign out_addr  = si_q + sj_q;
  // A latched length of 0 means 256, and 0 - 1 wraps to 255 as required.
  assign kidx_last = key_len_q - 8'd1;

  assign start_setup = key_setup_en && (state_q == ST_IDLE || state_q == ST_READY);

  // RAM addresses are per-state: a read issued in one state returns data in
  // the next, and a write commits at the edge that ends its state.
  always_comb begin
    raddr_c = 8'd0;
    wen_c   = 1'b0;
    waddr_c = 8'd0;
    wdata_c = 8'd0;
    case (state_q)
      ST_INIT:  begin wen_c = 1'b1; waddr_c = i_q; wdata_c = i_q; end
      ST_K_RDI: raddr_c = i_q;
      ST_K_RDJ: raddr_c = j_ksa;
      ST_K_WR1: begin wen_c = 1'b1; waddr_c = i_q; wdata_c = sbox_rdata; end
      ST_K_WR2: begin wen_c = 1'b1; waddr_c = j_q; wdata_c = si_q; end
      ST_P_RDI: raddr_c = i_inc;
      ST_P_RDJ: raddr_c = j_prga;
      ST_P_WR1: begin wen_c = 1'b1; waddr_c = i_q; wdata_c = sbox_rdata; end
      ST_P_WR2: begin wen_c = 1'b1; waddr_c = j_q; wdata_c = si_q; end
      ST_P_RDK, ST_P_OUT: raddr_c = out_addr;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      i_q         <= 8'd0;
      j_q         <= 8'd0;
      kidx_q      <= 8'd0;
      si_q        <= 8'd0;
      sj_q        <= 8'd0;
      key_len_q   <= 8'd0;
      rem_q       <= '0;
      ks_valid_q  <= 1'b0;
      key_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_setup) begin
        key_len_q   <= key_len;
        i_q         <= 8'd0;
        j_q         <= 8'd0;
        kidx_q      <= 8'd0;
        key_ready_q <= 1'b0;
        busy_q      <= 1'b1;
        state_q     <= ST_INIT;
      end else begin
        case (state_q)
          ST_INIT: begin
            i_q <= i_inc;
            if (i_q == byte_t'(SBOX_DEPTH - 1)) state_q <= ST_K_RDI;
          end
          ST_K_RDI: state_q <= ST_K_RDJ;
          ST_K_RDJ: begin
            si_q    <= sbox_rdata;
            j_q     <= j_ksa;
            state_q <= ST_K_WR1;
          end
          ST_K_WR1: state_q <= ST_K_WR2;
          ST_K_WR2: begin
            kidx_q <= (kidx_q == kidx_last) ? 8'd0 : kidx_q + 8'd1;
            i_q    <= i_inc;
            if (i_q == byte_t'(SBOX_DEPTH - 1)) begin
              j_q         <= 8'd0;
              key_ready_q <= 1'b1;
              busy_q      <= 1'b0;
              state_q     <= ST_READY;
            end else begin
              state_q <= ST_K_RDI;
            end
          end
          ST_READY: begin
            if (cipher_req) begin
              if (ks_count == '0) begin
                done_q <= 1'b1;
              end else begin
                rem_q   <= ks_count;
                busy_q  <= 1'b1;
                state_q <= ST_P_RDI;
              end
            end
          end
          ST_P_RDI: begin
            i_q     <= i_inc;
            state_q <= ST_P_RDJ;
          end
          ST_P_RDJ: begin
            si_q    <= sbox_rdata;
            j_q     <= j_prga;
            state_q <= ST_P_WR1;
          end
          ST_P_WR1: begin
            sj_q    <= sbox_rdata;
            state_q <= ST_P_WR2;
          end
          ST_P_WR2: state_q <= ST_P_RDK;
          ST_P_RDK: begin
            ks_valid_q <= 1'b1;
            state_q    <= ST_P_OUT;
          end
          // ks_valid holds with ks_byte stable until ks_ready; a byte moves
          // on any edge where both are high.
          ST_P_OUT: begin
            if (ks_ready) begin
              ks_valid_q <= 1'b0;
              rem_q      <= rem_q - CNT_W'(1);
              if (rem_q == CNT_W'(1)) begin
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= ST_READY;
              end else begin
                state_q <= ST_P_RDI;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign key_addr    = kidx_q;
  assign ks_valid    = ks_valid_q;
  assign ks_byte     = (state_q == ST_P_OUT) ? sbox_rdata : 8'd0;
  assign key_ready   = key_ready_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign sbox_raddr  = raddr_c;
  assign sbox_wen    = wen_c;
  assign sbox_waddr  = waddr_c;
  assign sbox_wdata  = wdata_c;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_rc4_sched.sv
// Bench for rc4_sched: external S-box RAM and key file, textbook RC4 reference
// model feeding an expected-byte queue, and a per-cycle output checker.
module tb_rc4_sched;
  import rc4_pkg::*;

  localparam int CNT_W = 16;

  // ---------------- clock / reset / DUT ----------------
  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             key_setup_en = 1'b0;
  logic [7:0]       key_len = 8'd0;
  logic [7:0]       key_addr;
  logic [7:0]       key_data;
  logic             cipher_req = 1'b0;
  logic [CNT_W-1:0] ks_count = '0;
  logic             ks_valid;
  logic             ks_ready = 1'b1;
  logic [7:0]       ks_byte;
  logic             key_ready, busy, done;
  logic [7:0]       sbox_raddr, sbox_rdata, sbox_waddr, sbox_wdata;
  logic             sbox_wen;
  rc4_state_e       dbg_state;

  always #5 clk = ~clk;

  rc4_sched #(.SBOX_AW(8), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .key_setup_en(key_setup_en), .key_len(key_len),
    .key_addr(key_addr), .key_data(key_data),
    .cipher_req(cipher_req), .ks_count(ks_count),
    .ks_valid(ks_valid), .ks_ready(ks_ready), .ks_byte(ks_byte),
    .key_ready(key_ready), .busy(busy), .done(done),
    .sbox_raddr(sbox_raddr), .sbox_rdata(sbox_rdata),
    .sbox_wen(sbox_wen), .sbox_waddr(sbox_waddr), .sbox_wdata(sbox_wdata),
    .dbg_state_o(dbg_state)
  );

  // External S-box RAM (synchronous read, old data on same-cycle collision) and key file.
  logic [7:0] ram [256];
  always @(posedge clk) begin
    if (sbox_wen) ram[sbox_waddr] <= sbox_wdata;
    sbox_rdata <= ram[sbox_raddr];
  end

  logic [7:0] key_mem [256];
  assign key_data = key_mem[key_addr];

  int cyc_now = 0;
  always @(posedge clk) cyc_now <= cyc_now + 1;

  // ---------------- scoreboard state ----------------
  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [7:0] model_log[$];
  logic [7:0] key_vec [10];
  logic [7:0] m_s [256];
  logic [7:0] m_i, m_j;
  logic       bp_mode = 1'b0;
  logic       stall_pending = 1'b0;
  logic [7:0] stall_byte;
  int         last_hs = -1;
  int         cur_len = 256;
  logic       key_seen [256];
  logic       key_addr_bad = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic note_fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  // ---------------- reference model: textbook RC4 ----------------
  task automatic model_key(input int len);
    logic [7:0] t;
    for (int k = 0; k < 256; k++) m_s[k] = 8'(k);
    m_j = 8'd0;
    for (int k = 0; k < 256; k++) begin
      m_j = m_j + m_s[k] + key_mem[k % len];
      t = m_s[k]; m_s[k] = m_s[m_j]; m_s[m_j] = t;
    end
    m_i = 8'd0;
    m_j = 8'd0;
  endtask

  task automatic model_gen(input int n);
    logic [7:0] t, idx;
    for (int k = 0; k < n; k++) begin
      m_i = m_i + 8'd1;
      m_j = m_j + m_s[m_i];
      t = m_s[m_i]; m_s[m_i] = m_s[m_j]; m_s[m_j] = t;
      idx = m_s[m_i] + m_s[m_j];
      exp_q.push_back(m_s[idx]);
      model_log.push_back(m_s[idx]);
    end
  endtask

  // ---------------- monitors (forked from the main process) ----------------
  task automatic compare_loop();
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        stall_pending = 1'b0;
        last_hs = -1;
      end else begin
        if (stall_pending) begin
          chk("stall_valid_hold", 32'(ks_valid), 1);
          chk("stall_byte_hold", 32'(ks_byte), 32'(stall_byte));
        end
        if (ks_valid && ks_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_byte: got 0x%0h, expected no byte (t=%0t)", ks_byte, $time);
          end else begin
            chk("ks_byte", 32'(ks_byte), 32'(exp_q.pop_front()));
          end
          got_q.push_back(ks_byte);
          if (!bp_mode && last_hs >= 0) chk("byte_gap", cyc_now - last_hs, 6);
          last_hs = cyc_now;
          stall_pending = 1'b0;
        end else if (ks_valid) begin
          stall_pending = 1'b1;
          stall_byte = ks_byte;
        end else begin
          stall_pending = 1'b0;
        end
        if (done) begin
          chk("done_in_ready", 32'(dbg_state), 32'(ST_READY));
          chk("done_not_busy", 32'(busy), 0);
          last_hs = -1;
        end
      end
    end
  endtask

  task automatic drive_ready();
    forever begin
      @(posedge clk);
      #1;
      ks_ready = bp_mode ? ($urandom_range(0, 99) < 30) : 1'b1;
    end
  endtask

  task automatic key_monitor();
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (dbg_state == ST_K_RDJ) key_seen[key_addr] = 1'b1;
        if (int'(key_addr) >= cur_len) key_addr_bad = 1'b1;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic chk_reset_outs(input string tag);
    chk({tag, "_ks_valid"}, 32'(ks_valid), 0);
    chk({tag, "_key_ready"}, 32'(key_ready), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_sbox_wen"}, 32'(sbox_wen), 0);
    chk({tag, "_ks_byte"}, 32'(ks_byte), 0);
    chk({tag, "_key_addr"}, 32'(key_addr), 0);
    chk({tag, "_raddr"}, 32'(sbox_raddr), 0);
    chk({tag, "_waddr"}, 32'(sbox_waddr), 0);
    chk({tag, "_wdata"}, 32'(sbox_wdata), 0);
    chk({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
  endtask

  // mode 0: plain; 1: stray cipher_req/key_setup_en during setup; 2: cipher_req together with key_setup_en
  task automatic key_setup(input int len, input int mode, output int lat);
    logic saw_valid;
    saw_valid = 1'b0;
    key_len = len[7:0];
    key_setup_en = 1'b1;
    if (mode == 2) begin
      cipher_req = 1'b1;
      ks_count = 16'd4;
    end
    lat = 0;
    while (1) begin
      @(posedge clk);
      lat++;
      #1;
      if (lat == 1) begin
        key_setup_en = 1'b0;
        cipher_req = 1'b0;
        cur_len = (len == 0) ? 256 : len;
        if (mode == 2) chk("simul_enters_init", 32'(dbg_state), 32'(ST_INIT));
      end
      if (mode == 1 && lat == 100) begin cipher_req = 1'b1; ks_count = 16'd5; end
      if (mode == 1 && lat == 101) cipher_req = 1'b0;
      if (mode == 1 && lat == 300) key_setup_en = 1'b1;
      if (mode == 1 && lat == 301) key_setup_en = 1'b0;
      if (ks_valid) saw_valid = 1'b1;
      if (key_ready) break;
      if (lat > 3000) begin
        note_fail("key_ready_wait");
        break;
      end
    end
    chk("setup_latency", lat, 1281);
    chk("no_valid_during_setup", 32'(saw_valid), 0);
    model_key(cur_len);
  endtask

  task automatic request(input int n, output int first_lat, output int done_cyc);
    int cyc;
    model_gen(n);
    ks_count = CNT_W'(n);
    cipher_req = 1'b1;
    first_lat = -1;
    done_cyc = -1;
    cyc = 0;
    while (done_cyc < 0) begin
      @(posedge clk);
      cyc++;
      #1;
      if (cyc == 1) cipher_req = 1'b0;
      if (ks_valid && first_lat < 0) first_lat = cyc;
      if (done) done_cyc = cyc;
      else if (cyc > 100 + 40 * n) begin
        note_fail("request_done_wait");
        break;
      end
    end
    if (done_cyc >= 0) begin
      @(posedge clk);
      #1;
      chk("done_single_cycle", 32'(done), 0);
    end
    chk("exp_drained", exp_q.size(), 0);
  endtask

  task automatic load_vector_key();
    key_mem[0] = 8'h4B;
    key_mem[1] = 8'h65;
    key_mem[2] = 8'h79;
  endtask

  task automatic check_vs_vector(input string tag);
    chk({tag, "_count"}, got_q.size(), 10);
    for (int k = 0; k < 10 && k < got_q.size(); k++)
      chk({tag, "_byte"}, 32'(got_q[k]), 32'(key_vec[k]));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int lat, fl, dc, hit, cyc, n_seen, len, cnt;
    key_vec = '{8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7, 8'h34, 8'hCA, 8'h72, 8'hA7, 8'h19};
    for (int k = 0; k < 256; k++) key_seen[k] = 1'b0;
    fork
      compare_loop();
      drive_ready();
      key_monitor();
    join_none

    repeat (3) @(posedge clk);
    #1;
    chk_reset_outs("reset");
    rst_n = 1'b1;

    // cipher_req in IDLE is ignored
    cipher_req = 1'b1;
    ks_count = 16'd3;
    @(posedge clk);
    #1;
    cipher_req = 1'b0;
    chk("idle_req_ignored_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("idle_req_ignored_busy", 32'(busy), 0);

    // "Key" vector, ready tied high, with stray requests during setup
    load_vector_key();
    key_setup(3, 1, lat);
    chk("key_ready_after_setup", 32'(key_ready), 1);
    got_q.delete();
    model_log.delete();
    request(10, fl, dc);
    chk("first_byte_latency", fl, 6);
    chk("done_cycle_10", dc, 61);
    for (int k = 0; k < 10 && k < model_log.size(); k++)
      chk("model_vs_vector", 32'(model_log[k]), 32'(key_vec[k]));
    check_vs_vector("vector");

    // split request: stream continuity across two requests
    key_setup(3, 0, lat);
    got_q.delete();
    request(5, fl, dc);
    request(5, fl, dc);
    chk("split_second_latency", fl, 6);
    check_vs_vector("split");

    // backpressure at ~30% ready duty
    key_setup(3, 0, lat);
    got_q.delete();
    bp_mode = 1'b1;
    request(10, fl, dc);
    bp_mode = 1'b0;
    check_vs_vector("backpressure");

    // zero-length request: done next cycle, no byte
    request(0, fl, dc);
    chk("zero_count_done_cycle", dc, 1);
    chk("zero_count_no_valid", fl, -1);

    // key_setup_en and cipher_req together in READY: re-key wins
    key_setup(3, 2, lat);
    bp_mode = 1'b1;
    request(7, fl, dc);
    bp_mode = 1'b0;

    // reset in the middle of keystream generation
    ks_count = 16'd20;
    cipher_req = 1'b1;
    cyc = 0;
    hit = 0;
    while (cyc < 20) begin
      @(posedge clk);
      cyc++;
      #1;
      if (cyc == 1) cipher_req = 1'b0;
      if (dbg_state == ST_P_WR1) begin
        hit = 1;
        break;
      end
    end
    chk("reached_p_wr1", hit, 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk_reset_outs("midrun_reset");
    rst_n = 1'b1;

    // 256-byte key via key_len=0, key bytes 00..FF
    for (int k = 0; k < 256; k++) begin
      key_mem[k] = 8'(k);
      key_seen[k] = 1'b0;
    end
    key_setup(0, 0, lat);
    n_seen = 0;
    for (int k = 0; k < 256; k++) if (key_seen[k]) n_seen++;
    chk("key_addr_coverage", n_seen, 256);
    bp_mode = 1'b1;
    request(16, fl, dc);
    bp_mode = 1'b0;

    // random keys, random counts, random backpressure
    for (int r = 0; r < 3; r++) begin
      len = $urandom_range(1, 32);
      for (int k = 0; k < len; k++) key_mem[k] = 8'($urandom_range(0, 255));
      key_setup(len, 0, lat);
      for (int q = 0; q < 2; q++) begin
        bp_mode = 1'($urandom_range(0, 1));
        cnt = $urandom_range(1, 12);
        request(cnt, fl, dc);
        chk("rand_first_latency", fl, 6);
      end
      bp_mode = 1'b0;
    end

    chk("key_addr_in_range", 32'(key_addr_bad), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
